stack_param: RTL and testbench
==============================

Name: stack_param

Overview:
- Parametrised LIFO stack; next generation of the lab's fixed 4-bit, 5-entry structural stack.
- Keeps the same 2-bit NOP/PUSH/POP/GET command interface.
- Adds generic width and depth, occupancy and status flags, an error strobe, and selectable overflow policy.
- Sits in the labwork datapath as a drop-in scratch stack driven by a command sequencer or testbench.

Parameters:
WIDTH, 4, data word width in bits (>=1)
DEPTH, 5, number of storage entries (>=2)
IDX_W, $clog2(DEPTH) (min 1), derived localparam, width of INDEX
CNT_W, $clog2(DEPTH+1), derived localparam, width of COUNT

Ports:
CLK  in  1  clock, all state changes on rising edge
RESET  in  1  synchronous, active-high reset, sampled on rising CLK edge
COMMAND  in  2  00 NOP, 01 PUSH, 10 POP, 11 GET
INDEX  in  IDX_W  GET offset from top (0 = top of stack)
I_DATA  in  WIDTH  PUSH data
O_DATA  out  WIDTH  registered read data (POP/GET result)
COUNT  out  CNT_W  current number of valid entries
EMPTY  out  1  COUNT == 0
FULL  out  1  COUNT == DEPTH
ERR  out  1  one-cycle strobe: illegal or degraded operation last cycle

Behaviour:
- Storage is a circular array mem[0..DEPTH-1]; TOP points to the next free slot.
- Pointer arithmetic is modulo DEPTH; the wrap from DEPTH-1 to 0 is explicit, not power-of-2 truncation.
- Reset (RESET=1 at posedge): all mem entries cleared to 0; TOP=0, COUNT=0, O_DATA=0, ERR=0, EMPTY=1, FULL=0.
- RESET has priority over COMMAND in the same cycle.
- Reset mid-sequence discards all contents; the next POP returns the empty-pop behaviour.
- All outputs are registered. EMPTY and FULL are decoded from the registered COUNT.
- Results appear one cycle after the command edge.
- ERR deasserts on the next cycle unless the next command also errs.
- NOP: no state change. O_DATA holds. ERR=0.
- PUSH, not full:
  - mem[TOP] <= I_DATA; TOP <= TOP+1 mod DEPTH; COUNT += 1.
  - O_DATA holds; ERR=0.
- PUSH, full: policy set by the optional feature.
- POP, not empty:
  - O_DATA <= mem[TOP-1 mod DEPTH]; TOP <= TOP-1 mod DEPTH; COUNT -= 1.
  - The popped slot is not cleared; ERR=0.
- POP, empty: TOP, COUNT and O_DATA unchanged; ERR=1.
- GET:
  - O_DATA <= mem[(TOP-1-INDEX) mod DEPTH]; no pointer or COUNT change.
  - If INDEX >= DEPTH (possible when DEPTH is not a power of 2), the offset is reduced mod DEPTH first.
  - If INDEX >= COUNT, data is still returned (stale or zero slot) and ERR=1; otherwise ERR=0.
- Back-to-back commands are allowed every cycle; there is no busy state.
- PUSH then POP on consecutive cycles returns the pushed word.
- Unknown/X COMMAND: treated as NOP (default branch).

Optional Feature:
- Macro: STACK_OVF_WRAP_EN.
- Defined:
  - PUSH on full overwrites the oldest entry: mem[TOP] <= I_DATA; TOP advances.
  - COUNT stays DEPTH; FULL stays 1; ERR=0.
  - This is the lab's circular-stack semantics.
- Undefined (default):
  - PUSH on full is rejected: mem, TOP and COUNT unchanged; ERR=1.
- All other behaviour is identical in both builds.

Test Plan:
- Reset then fill (WIDTH=4, DEPTH=5): RESET 1 cycle, PUSH 1,2,3,4,5 -> COUNT 1..5, FULL=1 after 5th push, EMPTY=0, ERR=0 throughout.
- GET sweep after fill: GET INDEX=0..4 -> O_DATA 5,4,3,2,1 one cycle after each; GET INDEX=5..7 -> O_DATA=mem[(TOP-1-INDEX) mod 5] (i.e. 5,4,3 again), ERR=1.
- Overflow push 6 when full:
  - Without macro -> ERR=1, COUNT=5, GET 0 returns 5.
  - With STACK_OVF_WRAP_EN -> ERR=0, GET 0 returns 6, GET 4 returns 2.
- Drain and underflow: 5 POPs -> O_DATA 5,4,3,2,1, EMPTY=1 after last; 6th POP -> ERR=1, O_DATA stays 1, COUNT=0.
- Interleaved POP/GET: after fill, alternate POP then GET INDEX=i for i=0..4 -> POP values 5..1; GET values valid while INDEX<COUNT, ERR=1 when INDEX>=COUNT.
- Reset mid-operation: push 3 values, assert RESET concurrently with PUSH 9 -> COUNT=0, O_DATA=0, EMPTY=1; following POP -> ERR=1; GET 0 -> O_DATA=0.

Source files
------------

// File: rtl/stack_param_if.sv
// Command/response bundle for stack_param.
// The command sequencer drives the master side and the stack is the slave.
interface stack_param_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5
);
    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [1:0]       COMMAND;
    logic [IDX_W-1:0] INDEX;
    logic [WIDTH-1:0] I_DATA;
    logic [WIDTH-1:0] O_DATA;
    logic [CNT_W-1:0] COUNT;
    logic             EMPTY;
    logic             FULL;
    logic             ERR;

    modport master (
        output COMMAND, INDEX, I_DATA,
        input  O_DATA, COUNT, EMPTY, FULL, ERR
    );

    modport slave (
        input  COMMAND, INDEX, I_DATA,
        output O_DATA, COUNT, EMPTY, FULL, ERR
    );
endinterface

// File: rtl/stack_param.sv
// Parametrised LIFO stack with NOP/PUSH/POP/GET commands, occupancy flags and an error strobe.
// Define STACK_OVF_WRAP_EN to let PUSH on a full stack overwrite the oldest entry instead of rejecting it.
module stack_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 5
) (
    input  logic         CLK,
    input  logic         RESET,
    stack_param_if.slave bus
);
    localparam int IDX_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = IDX_W + 1;

    localparam logic [IDX_W-1:0] LAST_SLOT  = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] DEPTH_W    = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        CMD_NOP  = 2'b00,
        CMD_PUSH = 2'b01,
        CMD_POP  = 2'b10,
        CMD_GET  = 2'b11
    } cmd_e;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] top_q;
    logic [IDX_W-1:0] top_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic [WIDTH-1:0] rdData_q;
    logic [WIDTH-1:0] rdData_d;
    logic             err_q;
    logic             err_d;

    logic             wrEn;
    logic [IDX_W-1:0] topPlus1;
    logic [IDX_W-1:0] topMinus1;
    logic [IDX_W-1:0] getAddr;
    logic [PTR_W-1:0] idxWide;
    logic [PTR_W-1:0] topM1Wide;
    logic [PTR_W-1:0] getWide;
    logic             isEmpty;
    logic             isFull;
    logic             getOutOfRange;

    assign isEmpty = (count_q == '0);
    assign isFull  = (count_q == FULL_COUNT);

    // Pointer steps wrap explicitly at DEPTH, which need not be a power of two.
    always_comb begin
        topPlus1  = (top_q == LAST_SLOT) ? '0 : top_q + 1'b1;
        topMinus1 = (top_q == '0) ? LAST_SLOT : top_q - 1'b1;
    end

    // GET slot is (TOP-1-INDEX) mod DEPTH; INDEX can exceed DEPTH-1, so it is reduced first.
    always_comb begin
        idxWide = {1'b0, bus.INDEX};
        if (idxWide >= DEPTH_W) begin
            idxWide = idxWide - DEPTH_W;
        end
        topM1Wide = {1'b0, topMinus1};
        if (topM1Wide >= idxWide) begin
            getWide = topM1Wide - idxWide;
        end else begin
            getWide = topM1Wide + DEPTH_W - idxWide;
        end
        getAddr       = getWide[IDX_W-1:0];
        getOutOfRange = (32'(bus.INDEX) >= 32'(count_q));
    end

    always_comb begin
        top_d    = top_q;
        count_d  = count_q;
        rdData_d = rdData_q;
        err_d    = 1'b0;
        wrEn     = 1'b0;
        case (bus.COMMAND)
            CMD_PUSH: begin
                if (!isFull) begin
                    wrEn    = 1'b1;
                    top_d   = topPlus1;
                    count_d = count_q + 1'b1;
                end else begin
`ifdef STACK_OVF_WRAP_EN
                    wrEn  = 1'b1;
                    top_d = topPlus1;
`else
                    err_d = 1'b1;
`endif
                end
            end
            CMD_POP: begin
                if (!isEmpty) begin
                    rdData_d = mem_q[topMinus1];
                    top_d    = topMinus1;
                    count_d  = count_q - 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
            CMD_GET: begin
                rdData_d = mem_q[getAddr];
                err_d    = getOutOfRange;
            end
            default: begin
            end
        endcase
    end

    // When full in wrap mode, top_q already points at the oldest entry, so the write replaces it.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wrEn) begin
            mem_q[top_q] <= bus.I_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            top_q    <= '0;
            count_q  <= '0;
            rdData_q <= '0;
            err_q    <= 1'b0;
        end else begin
            top_q    <= top_d;
            count_q  <= count_d;
            rdData_q <= rdData_d;
            err_q    <= err_d;
        end
    end

    assign bus.O_DATA = rdData_q;
    assign bus.COUNT  = count_q;
    assign bus.EMPTY  = isEmpty;
    assign bus.FULL   = isFull;
    assign bus.ERR    = err_q;
endmodule

// File: tb/tb_stack_param.sv
// Scoreboard bench for stack_param (WIDTH=4, DEPTH=5): directed commands queue hand-computed
// responses, and a monitor compares them one cycle later. Honours STACK_OVF_WRAP_EN.
module tb_stack_param;
    localparam int WIDTH = 4;
    localparam int DEPTH = 5;

    localparam logic [1:0] NOP  = 2'b00;
    localparam logic [1:0] PUSH = 2'b01;
    localparam logic [1:0] POP  = 2'b10;
    localparam logic [1:0] GET  = 2'b11;

`ifdef STACK_OVF_WRAP_EN
    localparam logic       OVF_ERR  = 1'b0;
    localparam logic [3:0] OVF_GET0 = 4'd6;
    localparam logic [3:0] OVF_GET4 = 4'd2;
`else
    localparam logic       OVF_ERR  = 1'b1;
    localparam logic [3:0] OVF_GET0 = 4'd5;
    localparam logic [3:0] OVF_GET4 = 4'd1;
`endif

    typedef struct packed {
        logic [3:0] data;
        logic [2:0] count;
        logic       empty;
        logic       full;
        logic       err;
    } exp_t;

    logic CLK;
    logic RESET;
    exp_t expQ[$];
    int   checkCount;
    int   errorCount;

    stack_param_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    stack_param #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, actual, expected);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("O_DATA", 32'(bus.O_DATA), 32'(e.data));
        checkField("COUNT",  32'(bus.COUNT),  32'(e.count));
        checkField("EMPTY",  32'(bus.EMPTY),  32'(e.empty));
        checkField("FULL",   32'(bus.FULL),   32'(e.full));
        checkField("ERR",    32'(bus.ERR),    32'(e.err));
    endtask

    // Drives one command at the falling edge and queues the response due after the next rising edge.
    task automatic applyStimulus(input logic rst, input logic [1:0] cmd, input logic [2:0] idx,
                                 input logic [3:0] din, input logic [3:0] eData,
                                 input logic [2:0] eCount, input logic eErr);
        exp_t e;
        @(negedge CLK);
        RESET       = rst;
        bus.COMMAND = cmd;
        bus.INDEX   = idx;
        bus.I_DATA  = din;
        e.data  = eData;
        e.count = eCount;
        e.empty = (eCount == 3'd0);
        e.full  = (eCount == 3'd5);
        e.err   = eErr;
        expQ.push_back(e);
    endtask

    always @(posedge CLK) begin
        #1;
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    initial begin
        checkCount  = 0;
        errorCount  = 0;
        RESET       = 1'b1;
        bus.COMMAND = NOP;
        bus.INDEX   = '0;
        bus.I_DATA  = '0;

        applyStimulus(1, NOP, 0, 0, 0, 0, 0);

        // Fill
        applyStimulus(0, PUSH, 0, 1, 0, 1, 0);
        applyStimulus(0, PUSH, 0, 2, 0, 2, 0);
        applyStimulus(0, PUSH, 0, 3, 0, 3, 0);
        applyStimulus(0, PUSH, 0, 4, 0, 4, 0);
        applyStimulus(0, PUSH, 0, 5, 0, 5, 0);

        // GET sweep, including INDEX beyond DEPTH
        applyStimulus(0, GET, 0, 0, 5, 5, 0);
        applyStimulus(0, GET, 1, 0, 4, 5, 0);
        applyStimulus(0, GET, 2, 0, 3, 5, 0);
        applyStimulus(0, GET, 3, 0, 2, 5, 0);
        applyStimulus(0, GET, 4, 0, 1, 5, 0);
        applyStimulus(0, GET, 5, 0, 5, 5, 1);
        applyStimulus(0, GET, 6, 0, 4, 5, 1);
        applyStimulus(0, GET, 7, 0, 3, 5, 1);
        applyStimulus(0, NOP, 0, 0, 3, 5, 0);

        // Overflow push
        applyStimulus(0, PUSH, 0, 6, 3, 5, OVF_ERR);
        applyStimulus(0, GET, 0, 0, OVF_GET0, 5, 0);
        applyStimulus(0, GET, 4, 0, OVF_GET4, 5, 0);

        // Refill from reset, then drain and underflow
        applyStimulus(1, NOP, 0, 0, 0, 0, 0);
        applyStimulus(0, PUSH, 0, 1, 0, 1, 0);
        applyStimulus(0, PUSH, 0, 2, 0, 2, 0);
        applyStimulus(0, PUSH, 0, 3, 0, 3, 0);
        applyStimulus(0, PUSH, 0, 4, 0, 4, 0);
        applyStimulus(0, PUSH, 0, 5, 0, 5, 0);
        applyStimulus(0, POP, 0, 0, 5, 4, 0);
        applyStimulus(0, POP, 0, 0, 4, 3, 0);
        applyStimulus(0, POP, 0, 0, 3, 2, 0);
        applyStimulus(0, POP, 0, 0, 2, 1, 0);
        applyStimulus(0, POP, 0, 0, 1, 0, 0);
        applyStimulus(0, POP, 0, 0, 1, 0, 1);

        // Interleaved POP/GET; GET hits stale slots once INDEX >= COUNT
        applyStimulus(1, NOP, 0, 0, 0, 0, 0);
        applyStimulus(0, PUSH, 0, 1, 0, 1, 0);
        applyStimulus(0, PUSH, 0, 2, 0, 2, 0);
        applyStimulus(0, PUSH, 0, 3, 0, 3, 0);
        applyStimulus(0, PUSH, 0, 4, 0, 4, 0);
        applyStimulus(0, PUSH, 0, 5, 0, 5, 0);
        applyStimulus(0, POP, 0, 0, 5, 4, 0);
        applyStimulus(0, GET, 0, 0, 4, 4, 0);
        applyStimulus(0, POP, 0, 0, 4, 3, 0);
        applyStimulus(0, GET, 1, 0, 2, 3, 0);
        applyStimulus(0, POP, 0, 0, 3, 2, 0);
        applyStimulus(0, GET, 2, 0, 5, 2, 1);
        applyStimulus(0, POP, 0, 0, 2, 1, 0);
        applyStimulus(0, GET, 3, 0, 3, 1, 1);
        applyStimulus(0, POP, 0, 0, 1, 0, 0);
        applyStimulus(0, GET, 4, 0, 1, 0, 1);

        // Reset mid-operation wins over a concurrent PUSH
        applyStimulus(0, PUSH, 0, 7, 1, 1, 0);
        applyStimulus(0, PUSH, 0, 8, 1, 2, 0);
        applyStimulus(0, PUSH, 0, 10, 1, 3, 0);
        applyStimulus(1, PUSH, 0, 9, 0, 0, 0);
        applyStimulus(0, POP, 0, 0, 0, 0, 1);
        applyStimulus(0, GET, 0, 0, 0, 0, 1);

        // Back-to-back PUSH then POP, and X command as NOP
        applyStimulus(0, PUSH, 0, 9, 0, 1, 0);
        applyStimulus(0, POP, 0, 0, 9, 0, 0);
        applyStimulus(0, 2'bxx, 0, 3, 9, 0, 0);

        @(negedge CLK);
        bus.COMMAND = NOP;
        repeat (3) @(negedge CLK);
        checkField("scoreboard drained", 32'(expQ.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
